trng_sample_packer: RTL and testbench

- Upstream stage of the TRNG AXI4 slave register file.
- Takes the raw entropy bit stream from the ring-oscillator sampler and applies von Neumann debiasing plus a repetition-count health test.
- Packs the debiased bits LSB-first into 32-bit words.
- Buffers the words in a small FIFO; the AXI slave pops words from it to serve burst reads of the random-data registers.

---
 rtl/trng_pkg.sv | 18 +
 rtl/trng_sample_packer_if.sv | 20 ++
 rtl/trng_word_fifo.sv | 73 +++++++
 rtl/trng_sample_packer.sv | 147 ++++++++++++++
 tb/tb_trng_sample_packer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/trng_pkg.sv
// Shared constants, types and helpers for the TRNG sample packer.
package trng_pkg;

    localparam int unsigned TRNG_DATA_WIDTH = 32;
    localparam int unsigned TRNG_FIFO_DEPTH = 8;
    localparam int unsigned TRNG_RCT_CUTOFF = 16;

    typedef enum logic [0:0] {
        PAIR_FIRST  = 1'b0,
        PAIR_SECOND = 1'b1
    } pair_state_t;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/trng_sample_packer_if.sv
// Word stream from the packer FIFO towards the AXI slave register file.
interface trng_sample_packer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] word_tdata;
    logic                  word_tvalid;
    logic                  word_tready;

    modport master (
        output word_tdata,
        output word_tvalid,
        input  word_tready
    );

    modport slave (
        input  word_tdata,
        input  word_tvalid,
        output word_tready
    );
endinterface

// File: rtl/trng_word_fifo.sv
// Registered synchronous word FIFO with sync clear; head word is zero when empty.
module trng_word_fifo
    import trng_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = TRNG_DATA_WIDTH,
    parameter int unsigned DEPTH      = TRNG_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         full,
    output logic                         empty,
    output logic [lvl_width(DEPTH)-1:0]  level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = lvl_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q,  level_d;
    logic                  do_push, do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign level = level_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;

    // Next pointer and level values; clear overrides push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      level_d = level_q + LW'(1);
            else if (do_pop && !do_push) level_d = level_q - LW'(1);
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/trng_sample_packer.sv
// Von Neumann debiaser, repetition-count health test and LSB-first word packer.
module trng_sample_packer
    import trng_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = TRNG_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = TRNG_FIFO_DEPTH,
    parameter int unsigned RCT_CUTOFF = TRNG_RCT_CUTOFF
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic                              enable,
    input  logic                              clear,
    input  logic                              raw_bit,
    input  logic                              raw_valid,
    trng_sample_packer_if.master              word_if,
    output logic [lvl_width(FIFO_DEPTH)-1:0]  fifo_level,
    output logic                              overflow,
    output logic                              health_fail
);

    localparam int unsigned CW = $clog2(DATA_WIDTH);

    pair_state_t           pair_q, pair_d;
    logic                  b0_q, b0_d;
    // Only the last DATA_WIDTH-1 emitted bits are held; the completing bit is
    // concatenated on top when the word is pushed, so word bit 0 is the oldest.
    logic [DATA_WIDTH-2:0] shreg_q, shreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            rct_q, rct_d;
    logic                  prev_q, prev_d;
    logic                  hf_q, hf_d;
    logic                  ovf_q, ovf_d;

    logic                  accept, emit, ebit, push;
    logic [DATA_WIDTH-1:0] push_word;
    logic                  fifo_full, fifo_empty;

    assign accept    = enable && raw_valid && !hf_q && !clear;
    assign push_word = {ebit, shreg_q};

    // Pair state machine: unequal pairs emit their first bit.
    always_comb begin
        pair_d = pair_q;
        b0_d   = b0_q;
        emit   = 1'b0;
        ebit   = b0_q;
        if (clear || !enable) begin
            pair_d = PAIR_FIRST;
        end else if (accept) begin
            case (pair_q)
                PAIR_FIRST: begin
                    b0_d   = raw_bit;
                    pair_d = PAIR_SECOND;
                end
                default: begin
                    emit   = (b0_q != raw_bit);
                    pair_d = PAIR_FIRST;
                end
            endcase
        end
    end

    // Packer: shift emitted bits in from the top, push on the word boundary.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        if (clear) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (emit) begin
            shreg_d = {ebit, shreg_q[DATA_WIDTH-2:1]};
            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                cnt_d = '0;
                push  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Repetition-count test on accepted raw bits, plus sticky overflow.
    always_comb begin
        rct_d  = rct_q;
        prev_d = prev_q;
        hf_d   = hf_q;
        ovf_d  = ovf_q;
        if (clear) begin
            rct_d  = '0;
            prev_d = 1'b0;
            hf_d   = 1'b0;
            ovf_d  = 1'b0;
        end else begin
            if (accept) begin
                prev_d = raw_bit;
                if (rct_q != '0 && raw_bit == prev_q) rct_d = rct_q + 8'd1;
                else                                  rct_d = 8'd1;
                if (rct_d == 8'(RCT_CUTOFF)) hf_d = 1'b1;
            end
            if (push && fifo_full && !word_if.word_tready) ovf_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pair_q  <= PAIR_FIRST;
            b0_q    <= 1'b0;
            shreg_q <= '0;
            cnt_q   <= '0;
            rct_q   <= '0;
            prev_q  <= 1'b0;
            hf_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pair_q  <= pair_d;
            b0_q    <= b0_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            rct_q   <= rct_d;
            prev_q  <= prev_d;
            hf_q    <= hf_d;
            ovf_q   <= ovf_d;
        end
    end

    trng_word_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .clear (clear),
        .push  (push),
        .din   (push_word),
        .pop   (word_if.word_tready),
        .dout  (word_if.word_tdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign word_if.word_tvalid = !fifo_empty;
    assign overflow            = ovf_q;
    assign health_fail         = hf_q;

endmodule

// File: tb/tb_trng_sample_packer.sv
// Scoreboard bench for trng_sample_packer: directed raw-bit sequences.
module tb_trng_sample_packer;

    logic       ACLK = 1'b0;
    logic       ARESETN;
    logic       enable, clear, raw_bit, raw_valid;
    logic [3:0] fifo_level;
    logic       overflow, health_fail;

    trng_sample_packer_if #(.DATA_WIDTH(32)) word_if ();

    trng_sample_packer #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (8),
        .RCT_CUTOFF (16)
    ) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .enable      (enable),
        .clear       (clear),
        .raw_bit     (raw_bit),
        .raw_valid   (raw_valid),
        .word_if     (word_if.master),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .health_fail (health_fail)
    );

    always #5 ACLK = ~ACLK;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    logic [31:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        raw_bit   = b;
        raw_valid = 1'b1;
        @(posedge ACLK);
        #1;
        raw_valid = 1'b0;
    endtask

    task automatic send_pair(input logic a, input logic b);
        send_bit(a);
        send_bit(b);
    endtask

    // Encode each bit of v as a raw pair (1 -> "1,0", 0 -> "0,1"), LSB first.
    // With raise_last, word_tready is high only on the word-completing edge.
    task automatic send_word(input logic [31:0] v, input bit raise_last);
        for (int i = 0; i < 32; i++) begin
            send_bit(v[i]);
            if (raise_last && i == 31) word_if.word_tready = 1'b1;
            send_bit(!v[i]);
            word_if.word_tready = 1'b0;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge ACLK);
        #1;
        clear = 1'b0;
    endtask

    task automatic drain(input string name);
        word_if.word_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge ACLK);
            #1;
            if (fifo_level == 4'd0) break;
        end
        word_if.word_tready = 1'b0;
        check({name, "_level"}, 32'(fifo_level), 32'd0);
        check({name, "_tvalid"}, 32'(word_if.word_tvalid), 32'd0);
    endtask

    // Monitor: every handshake pops the oldest expected word.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge ACLK);
            if (ARESETN && word_if.word_tvalid && word_if.word_tready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_mis++;
                    $display("FAIL sb_unexpected: got 0x%0h expected no word", word_if.word_tdata);
                end else begin
                    exp = sb.pop_front();
                    if (word_if.word_tdata !== exp) begin
                        n_mis++;
                        $display("FAIL sb_word: got 0x%0h expected 0x%0h", word_if.word_tdata, exp);
                    end
                end
            end
        end
    end

    initial begin
        ARESETN = 1'b0;
        enable = 1'b1; clear = 1'b0; raw_bit = 1'b0; raw_valid = 1'b0;
        word_if.word_tready = 1'b0;
        #2;
        check("rst_tvalid", 32'(word_if.word_tvalid), 32'd0);
        check("rst_tdata", word_if.word_tdata, 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_flags", {30'd0, overflow, health_fail}, 32'd0);
        #20 ARESETN = 1'b1;
        @(posedge ACLK);
        #1;

        // All-ones word
        for (int i = 0; i < 31; i++) send_pair(1'b1, 1'b0);
        send_bit(1'b1);
        check("ones_tvalid_early", 32'(word_if.word_tvalid), 32'd0);
        send_bit(1'b0);
        sb.push_back(32'hFFFF_FFFF);
        check("ones_tvalid", 32'(word_if.word_tvalid), 32'd1);
        check("ones_tdata", word_if.word_tdata, 32'hFFFF_FFFF);
        check("ones_level", 32'(fifo_level), 32'd1);
        drain("ones_pop");

        // Bit ordering: first emitted bit lands in bit 0
        send_pair(1'b1, 1'b0);
        for (int i = 0; i < 31; i++) send_pair(1'b0, 1'b1);
        sb.push_back(32'h0000_0001);
        check("order_level", 32'(fifo_level), 32'd1);
        check("order_tdata", word_if.word_tdata, 32'h0000_0001);
        word_if.word_tready = 1'b1;
        @(posedge ACLK);
        #1;
        word_if.word_tready = 1'b0;
        check("order_pop_level", 32'(fifo_level), 32'd0);
        check("order_pop_tvalid", 32'(word_if.word_tvalid), 32'd0);

        // Equal pairs and half pairs cut by enable=0 emit nothing
        for (int k = 0; k < 40; k++) begin
            logic b;
            b = k[0];
            if (k % 4 == 1) begin
                send_bit(b);
                enable = 1'b0;
                send_bit(!b);
                enable = 1'b1;
            end
            send_pair(b, b);
        end
        check("discard_level", 32'(fifo_level), 32'd0);
        check("discard_hf", 32'(health_fail), 32'd0);

        // Overflow: ninth word dropped
        for (int v = 0; v < 9; v++) begin
            if (v < 8) sb.push_back(32'(v));
            send_word(32'(v), 1'b0);
            if (v == 7) check("ovf_before", 32'(overflow), 32'd0);
        end
        check("ovf_level", 32'(fifo_level), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        drain("ovf_drain");

        pulse_clear();
        check("clr1_ovf", 32'(overflow), 32'd0);

        // Push and pop on the same edge while full
        for (int v = 0; v < 8; v++) begin
            sb.push_back(32'h10 + 32'(v));
            send_word(32'h10 + 32'(v), 1'b0);
        end
        check("pp_full_level", 32'(fifo_level), 32'd8);
        sb.push_back(32'h18);
        send_word(32'h18, 1'b1);
        check("pp_level", 32'(fifo_level), 32'd8);
        check("pp_ovf", 32'(overflow), 32'd0);
        drain("pp_drain");

        // Repetition-count trip
        pulse_clear();
        for (int i = 0; i < 15; i++) send_bit(1'b1);
        check("rct_hf_15", 32'(health_fail), 32'd0);
        send_bit(1'b1);
        check("rct_hf_16", 32'(health_fail), 32'd1);
        for (int i = 0; i < 32; i++) send_pair(1'b1, 1'b0);
        check("rct_blocked_level", 32'(fifo_level), 32'd0);
        check("rct_blocked_tvalid", 32'(word_if.word_tvalid), 32'd0);
        pulse_clear();
        check("rct_clr_hf", 32'(health_fail), 32'd0);
        check("rct_clr_ovf", 32'(overflow), 32'd0);
        check("rct_clr_level", 32'(fifo_level), 32'd0);

        // Async reset mid-word with buffered words
        send_word(32'h1234_5678, 1'b0);
        send_word(32'hA5A5_5A5A, 1'b0);
        send_word(32'h0F0F_F0F0, 1'b0);
        for (int i = 0; i < 20; i++) send_pair(1'b1, 1'b0);
        check("ar_level_pre", 32'(fifo_level), 32'd3);
        #2 ARESETN = 1'b0;
        #1;
        check("ar_tvalid", 32'(word_if.word_tvalid), 32'd0);
        check("ar_tdata", word_if.word_tdata, 32'd0);
        check("ar_level", 32'(fifo_level), 32'd0);
        check("ar_flags", {30'd0, overflow, health_fail}, 32'd0);
        #10 ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        for (int i = 0; i < 32; i++) send_pair(1'b1, 1'b0);
        sb.push_back(32'hFFFF_FFFF);
        check("ar_fresh_level", 32'(fifo_level), 32'd1);
        drain("ar_drain");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
